// File: rtl/trace_tx_framer_pkg.sv
// Shared types and constants for the acquisition-record UART framer.
// Frame layout: header, 48 shadow bytes, SAMPLES sensor bytes, checksum.
package trace_tx_framer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_BLK   = 3'd2,
    S_FETCH = 3'd3,
    S_MEM   = 3'd4,
    S_WAIT  = 3'd5,
    S_CHK   = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // Where WAIT resumes once uart_tx reports the byte complete.
  typedef enum logic [2:0] {
    N_BLK         = 3'd0,
    N_FETCH_FIRST = 3'd1,
    N_FETCH_INC   = 3'd2,
    N_CHK         = 3'd3,
    N_FIN         = 3'd4
  } next_t;

  localparam logic [7:0] HDR_DEFAULT    = 8'hA5;
  localparam int         BLK_BYTES      = 48;
  localparam logic [5:0] BLK_LAST       = 6'd47;
  localparam int         FRAME_OVERHEAD = BLK_BYTES + 2;

  function automatic int frame_len(input int samples);
    return FRAME_OVERHEAD + samples;
  endfunction

endpackage

// File: rtl/trace_tx_framer_byte_sel48.sv
// Byte selector over the 384-bit {pt,key,ct} shadow; index 0 is the
// most significant byte of pt, index 47 the least significant of ct.
module trace_tx_framer_byte_sel48
  import trace_tx_framer_pkg::*;
(
  input  logic [383:0] i_shadow,
  input  logic [5:0]   i_idx,
  output logic [7:0]   o_byte
);

  logic [8:0] w_msb;

  assign w_msb = 9'd383 - {i_idx, 3'b000};

  // Byte mux; indices past the block read as zero.
  always_comb begin
    if (i_idx <= BLK_LAST) begin
      o_byte = i_shadow[w_msb -: 8];
    end else begin
      o_byte = 8'h00;
    end
  end

endmodule

// File: rtl/trace_tx_framer.sv
// Serialises one acquisition record into a framed, XOR-checksummed byte
// stream for uart_tx, pacing each byte on the transmitter's done pulse.
module trace_tx_framer
  import trace_tx_framer_pkg::*;
#(
  parameter int         SAMPLES = 1024,
  parameter int         AW      = 10,
  parameter logic [7:0] HDR     = HDR_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [127:0]  pt,
  input  logic [127:0]  key,
  input  logic [127:0]  ct,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          tx_dv,
  output logic [7:0]    tx_byte,
  input  logic          tx_done,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLES - 1);

  state_t        r_state,  w_state_nxt;
  next_t         r_next,   w_next_nxt;
  logic [5:0]    r_idx,    w_idx_nxt;
  logic [383:0]  r_shadow, w_shadow_nxt;
  logic [7:0]    r_chk,    w_chk_nxt;
  logic [AW-1:0] r_addr,   w_addr_nxt;
  logic          r_tx_dv,  w_tx_dv_nxt;
  logic [7:0]    r_tx_byte, w_tx_byte_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_done,   w_done_nxt;
  logic [7:0]    w_blk_byte;

  trace_tx_framer_byte_sel48 u_sel (
    .i_shadow (r_shadow),
    .i_idx    (r_idx),
    .o_byte   (w_blk_byte)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_next    <= N_BLK;
      r_idx     <= 6'd0;
      r_shadow  <= 384'd0;
      r_chk     <= 8'h00;
      r_addr    <= {AW{1'b0}};
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_next    <= w_next_nxt;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      r_chk     <= w_chk_nxt;
      r_addr    <= w_addr_nxt;
      r_tx_dv   <= w_tx_dv_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; tx_dv and done default to idle-low pulses.
  always_comb begin
    w_state_nxt   = r_state;
    w_next_nxt    = r_next;
    w_idx_nxt     = r_idx;
    w_shadow_nxt  = r_shadow;
    w_chk_nxt     = r_chk;
    w_addr_nxt    = r_addr;
    w_tx_dv_nxt   = 1'b0;
    w_tx_byte_nxt = r_tx_byte;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shadow_nxt = {pt, key, ct};
          w_chk_nxt    = 8'h00;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_HDR;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_HDR: begin
        w_tx_byte_nxt = HDR;
        w_tx_dv_nxt   = 1'b1;
        w_idx_nxt     = 6'd0;
        w_next_nxt    = N_BLK;
        w_state_nxt   = S_WAIT;
      end
      S_BLK: begin
        w_tx_byte_nxt = w_blk_byte;
        w_tx_dv_nxt   = 1'b1;
        w_chk_nxt     = r_chk ^ w_blk_byte;
        w_state_nxt   = S_WAIT;
        if (r_idx == BLK_LAST) begin
          w_addr_nxt = {AW{1'b0}};
          w_next_nxt = N_FETCH_FIRST;
        end else begin
          w_idx_nxt  = r_idx + 6'd1;
          w_next_nxt = N_BLK;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_MEM;
      end
      S_MEM: begin
        w_tx_byte_nxt = mem_data;
        w_tx_dv_nxt   = 1'b1;
        w_chk_nxt     = r_chk ^ mem_data;
        w_state_nxt   = S_WAIT;
        if (r_addr == LAST_ADDR) begin
          w_next_nxt = N_CHK;
        end else begin
          w_next_nxt = N_FETCH_INC;
        end
      end
      S_WAIT: begin
        // A done pulse coincident with our own strobe belongs to an older byte.
        if (tx_done && !r_tx_dv) begin
          case (r_next)
            N_BLK:         w_state_nxt = S_BLK;
            N_FETCH_FIRST: w_state_nxt = S_FETCH;
            N_FETCH_INC: begin
              w_addr_nxt  = r_addr + {{(AW-1){1'b0}}, 1'b1};
              w_state_nxt = S_FETCH;
            end
            N_CHK:         w_state_nxt = S_CHK;
            N_FIN:         w_state_nxt = S_FIN;
            default:       w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_CHK: begin
        w_tx_byte_nxt = r_chk;
        w_tx_dv_nxt   = 1'b1;
        w_next_nxt    = N_FIN;
        w_state_nxt   = S_WAIT;
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_addr = r_addr;
  assign tx_dv    = r_tx_dv;
  assign tx_byte  = r_tx_byte;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
